// File: rtl/post_div_op_pkg.sv
// Shared widths, state encoding and special result values for the
// post-divide sign-restoration stage.
package post_div_op_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NEG_Q = 2'd1,
    ST_NEG_R = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/post_div_op_neg32.sv
// Two's-complement negator shared by the quotient and remainder paths;
// wraps modulo 2^WIDTH, carry-out dropped.
module neg32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = ~x + WIDTH'(1);

endmodule

// File: rtl/post_div_op.sv
// Restores quotient/remainder signs after the unsigned divider core and
// flags divide-by-zero and the -2^31 / -1 overflow.
//
// state    | meaning
// ST_IDLE  | waiting for a divider result (in_ready=1)
// ST_NEG_Q | negating the quotient register
// ST_NEG_R | negating the remainder register
// ST_DONE  | result held until the consumer accepts it
module post_div_op
  import post_div_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_quot,
  input  logic [WIDTH-1:0] in_rem,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             div_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_exception
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_r_q, neg_r_d;
  logic             exc_q, exc_d;
  logic             valid_q, valid_d;
  logic             neg_q_w;
  logic [WIDTH-1:0] neg_in, neg_out;

  assign neg_in = (state_q == ST_NEG_R) ? rem_q : quot_q;

  neg32 #(.WIDTH(WIDTH)) u_neg (
    .x (neg_in),
    .y (neg_out)
  );

  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    neg_r_d = neg_r_q;
    exc_d   = exc_q;
    valid_d = 1'b0;
    neg_q_w = sign_a ^ sign_b;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rem_d   = in_rem;
          neg_r_d = sign_a;
          if (div_zero) begin
            quot_d  = DIV0_QUOT;
            exc_d   = 1'b1;
            neg_r_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            quot_d = in_quot;
            // A 2^31 magnitude is only representable when the quotient goes negative.
            exc_d  = (in_quot == INT_MIN) && !neg_q_w;
            if (neg_q_w)     state_d = ST_NEG_Q;
            else if (sign_a) state_d = ST_NEG_R;
            else             state_d = ST_DONE;
          end
        end
      end
      ST_NEG_Q: begin
        quot_d  = neg_out;
        state_d = neg_r_q ? ST_NEG_R : ST_DONE;
      end
      ST_NEG_R: begin
        rem_d   = neg_out;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // out_valid rises one cycle after entering DONE and falls after the accept.
        valid_d = ~(valid_q & out_ready);
        if (valid_q && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      neg_r_q <= 1'b0;
      exc_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      neg_r_q <= neg_r_d;
      exc_q   <= exc_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = valid_q;
  assign out_quot      = quot_q;
  assign out_rem       = rem_q;
  assign out_exception = exc_q;

endmodule

// File: tb/tb_post_div_op.sv
// Directed and randomized bench for post_div_op; expectations come from
// signed integer division of the original operands.
module tb_post_div_op;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_quot;
  logic [31:0] in_rem;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quot;
  logic [31:0] out_rem;
  logic        out_exception;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  post_div_op dut (
    .clock         (clock),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_quot       (in_quot),
    .in_rem        (in_rem),
    .sign_a        (sign_a),
    .sign_b        (sign_b),
    .div_zero      (div_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quot      (out_quot),
    .out_rem       (out_rem),
    .out_exception (out_exception)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Divider-core view plus expected signed result for dividend a / divisor b.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mq, output logic [31:0] mr,
                       output logic [31:0] eq, output logic [31:0] er,
                       output logic ex, output int lat);
    logic [31:0] abs_a, abs_b;
    longint      sa, sb, q, r;
    abs_a = a[31] ? -a : a;
    abs_b = b[31] ? -b : b;
    if (b == 32'd0) begin
      mq  = $urandom;
      mr  = abs_a;
      eq  = 32'hFFFF_FFFF;
      er  = abs_a;
      ex  = 1'b1;
      lat = 1;
    end else begin
      mq  = abs_a / abs_b;
      mr  = abs_a % abs_b;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = sa / sb;
      r   = sa % sb;
      eq  = q[31:0];
      er  = r[31:0];
      ex  = (q == 64'sd2147483648);
      lat = 1 + int'(a[31] ^ b[31]) + int'(a[31]);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] mq, mr, eq, er, sq, sr;
    logic        ex;
    int          lat, cnt;
    model(a, b, mq, mr, eq, er, ex, lat);
    @(negedge clock);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_quot  = mq;
    in_rem   = mr;
    sign_a   = a[31];
    sign_b   = b[31];
    div_zero = (b == 32'd0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    #1 in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 12) begin
      @(posedge clock);
      #1 cnt++;
    end
    check("latency", cnt, lat);
    check("quot", out_quot, eq);
    check("rem", out_rem, er);
    check("exception", {31'd0, out_exception}, {31'd0, ex});
    sq = out_quot;
    sr = out_rem;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_quot  = $urandom;
      in_rem   = $urandom;
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clock);
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_quot", out_quot, sq);
      check("hold_rem", out_rem, sr);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_quot   = '0;
    in_rem    = '0;
    sign_a    = 1'b0;
    sign_b    = 1'b0;
    div_zero  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quot", out_quot, 32'd0);
    check("rst_rem", out_rem, 32'd0);
    check("rst_exc", {31'd0, out_exception}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    run_op(32'd7, -32'd2, 0);
    run_op(-32'd7, 32'd2, 0);
    run_op(-32'd7, -32'd2, 0);
    run_op(32'd8, 32'd4, 0);
    run_op(32'd5, 32'd0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(32'h8000_0000, 32'd1, 0);
    run_op(-32'd9, 32'd3, 0);
    run_op(32'd7, -32'd2, 5);

    // Abort during NEG_Q.
    @(negedge clock);
    in_quot  = 32'd3;
    in_rem   = 32'd1;
    sign_a   = 1'b0;
    sign_b   = 1'b1;
    div_zero = 1'b0;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_quot", out_quot, 32'd0);
    check("abort_rem", out_rem, 32'd0);
    check("abort_exc", {31'd0, out_exception}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("post_abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_abort_valid", {31'd0, out_valid}, 32'd0);
    run_op(-32'd7, -32'd2, 1);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = $urandom_range(1, 20) * (($urandom_range(0, 1) == 1) ? -32'd1 : 32'd1);
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(a, b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/post_div_op.md
Name: post_div_op

Overview:
- Sign-restoration stage placed after the unsigned multicycle divider core.
- Takes the unsigned quotient and remainder magnitudes, plus the operand signs captured before the divide. Produces the signed quotient and remainder.
- Flags divide-by-zero and the single signed-overflow case (-2^31 / -1).
- Uses one shared 32-bit two's-complement negator, time-multiplexed by a small FSM; valid/ready on both sides.

Parameters:
- WIDTH, 32, datapath width in bits. Only 32 is supported.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  divider core presents a result
- in_ready  out  1  block can accept a result
- in_quot  in  32  unsigned quotient magnitude
- in_rem  in  32  unsigned remainder magnitude
- sign_a  in  1  dividend sign bit (bit 31 of the original dividend)
- sign_b  in  1  divisor sign bit
- div_zero  in  1  original divisor was zero
- out_valid  out  1  signed result available
- out_ready  in  1  consumer accepts the result
- out_quot  out  32  signed quotient
- out_rem  out  32  signed remainder
- out_exception  out  1  divide-by-zero or overflow

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, out_valid=0, out_quot=0, out_rem=0, out_exception=0, internal registers cleared.
- in_ready=1 only in IDLE. A transfer occurs on a rising edge with in_valid & in_ready. On transfer, latch in_quot, in_rem, sign_a, sign_b, div_zero.
- Sign rules:
  - neg_q = sign_a XOR sign_b.
  - neg_r = sign_a (remainder takes the dividend's sign; truncating division).
- Negation = (~x) + 1, performed by the neg32 sub-module. Wrap is modulo 2^32 and the carry-out is ignored.
- FSM states IDLE, NEG_Q, NEG_R, DONE.
- IDLE, on transfer:
  - div_zero=1: go to DONE.
  - otherwise neg_q=1: go to NEG_Q.
  - otherwise neg_r=1: go to NEG_R.
  - otherwise: go to DONE.
- NEG_Q: one cycle; quotient register <= neg32(quotient). Then go to NEG_R if neg_r, else DONE.
- NEG_R: one cycle; remainder register <= neg32(remainder). Then go to DONE.
- DONE:
  - out_valid=1; outputs driven from registers and held stable.
  - On out_valid & out_ready go to IDLE, and out_valid drops the next cycle.
- Latency: with transfer at edge k, out_valid=1 after edge k+1+nq+nr, where nq/nr ∈ {0,1} are the negation steps taken.
- Divide-by-zero: out_quot=0xFFFFFFFF, out_rem=latched in_rem (passed through, no negation), out_exception=1.
- Overflow check, evaluated in IDLE on transfer and registered:
  - Magnitude 0x80000000 with neg_q=0 is overflow. Set out_exception=1 and out_quot=0x80000000 (negation skipped).
  - Magnitude 0x80000000 with neg_q=1 is the legal result -2^31; out_exception=0.
- Negating a zero remainder yields 0; no special case.
- in_valid while not in IDLE is ignored; the producer must hold its data.
- out_ready while not in DONE is ignored.
- resetn asserted mid-operation aborts immediately; the in-flight result is discarded.

Decomposition:
- Shared package holds:
  - WIDTH.
  - State encoding ST_IDLE=2'd0, ST_NEG_Q=2'd1, ST_NEG_R=2'd2, ST_DONE=2'd3.
  - Constants INT_MIN=32'h80000000 and DIV0_QUOT=32'hFFFFFFFF.
- Sub-module neg32:
  - Purely combinational: input x, output (~x)+1.
  - One instance, input muxed between the quotient and remainder registers by state.

Test Plan:
- 7 / -2: in_quot=3, in_rem=1, sign_a=0, sign_b=1 -> out_quot=0xFFFFFFFD, out_rem=1, exception=0, out_valid 2 cycles after transfer.
- -7 / 2: in_quot=3, in_rem=1, sign_a=1, sign_b=0 -> out_quot=0xFFFFFFFD, out_rem=0xFFFFFFFF, latency 3 cycles.
- -7 / -2 -> out_quot=3, out_rem=0xFFFFFFFF, latency 2. Then 8 / 4 (both signs 0, rem 0) -> out_quot=2, out_rem=0, latency 1.
- div_zero=1, in_rem=5 -> out_quot=0xFFFFFFFF, out_rem=5, exception=1, latency 1.
- Overflow and legal minimum:
  - in_quot=0x80000000, sign_a=1, sign_b=1 -> out_quot=0x80000000, exception=1.
  - Same magnitude with sign_b=0 -> out_quot=0x80000000, exception=0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored.
  - Pulse resetn low during NEG_Q -> all outputs 0 asynchronously, state IDLE, in_ready=1 after release.
